// File: rtl/conv_pkg.sv
// Shared CONV definitions: FSM state encoding and default address/geometry widths
// used by the read-address generator, the read mux and the address consumers.
package conv_pkg;

  localparam int unsigned CONV_AW   = 13;
  localparam int unsigned CONV_DIMW = 8;
  localparam int unsigned CONV_KW   = 3;
  localparam int unsigned CONV_SW   = 2;

  typedef enum logic [1:0] {
    CONV_IDLE = 2'd0,
    CONV_RUN  = 2'd1,
    CONV_FIN  = 2'd2
  } conv_state_e;

endpackage

// File: rtl/axi_frs.sv
// Forward register slice: registers valid/data towards the sink; ready passes
// through combinationally so a full slice can still stream one beat per cycle.
module axi_frs #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready_c,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  assign s_ready_c = !valid_q || m_ready;

  // Load a new beat whenever the held one is gone or leaving this cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (s_ready_c) begin
      valid_d = s_valid;
      if (s_valid) begin
        data_d = s_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;

endmodule

// File: rtl/conv_raddr_gen.sv
// Sliding-window read-address generator: streams one RAM address per kernel tap,
// window-major raster order, with first/last flags delimiting each window.
module conv_raddr_gen
  import conv_pkg::*;
#(
  parameter int unsigned AW   = CONV_AW,
  parameter int unsigned DIMW = CONV_DIMW,
  parameter int unsigned KW   = CONV_KW,
  parameter int unsigned SW   = CONV_SW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [AW-1:0]   cfg_base,
  input  logic [DIMW-1:0] cfg_width,
  input  logic [DIMW-1:0] cfg_height,
  input  logic [KW-1:0]   cfg_k,
  input  logic [SW-1:0]   cfg_stride,
  output logic            busy,
  output logic            done,
  output logic            cfg_err,
  output logic [AW-1:0]   m_addr,
  output logic            m_addr_first,
  output logic            m_addr_last,
  output logic            m_addr_valid,
  input  logic            m_addr_ready
);

  localparam int unsigned CW = DIMW + 1;
  localparam int unsigned DW = AW + 2;

  localparam logic [1:0] ST_IDLE = CONV_IDLE;
  localparam logic [1:0] ST_RUN  = CONV_RUN;
  localparam logic [1:0] ST_FIN  = CONV_FIN;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] k_q, k_d, s_q, s_d, w_q, w_d, h_q, h_d;
  logic [AW-1:0] pitch_q, pitch_d, spitch_q, spitch_d;
  logic [CW-1:0] kx_q, kx_d, ky_q, ky_d, x0_q, x0_d, y0_q, y0_d;
  logic [AW-1:0] addr_q, addr_d, tap_row_addr_q, tap_row_addr_d;
  logic [AW-1:0] win_addr_q, win_addr_d, win_row_addr_q, win_row_addr_d;
  logic          gen_done_q, gen_done_d;
  logic          busy_q, busy_d, done_q, done_d, err_q, err_d;

  logic [CW-1:0] cfg_k_c, cfg_s_c, cfg_w_c, cfg_h_c;
  logic [AW-1:0] cfg_pitch_c, cfg_spitch_c;
  logic          cfg_ok_c;

  logic [CW-1:0] cur_k, cur_s, cur_w, cur_h, cur_kx, cur_ky, cur_x0, cur_y0;
  logic [AW-1:0] cur_pitch, cur_spitch, cur_addr, cur_tap_row, cur_win, cur_win_row;

  logic [CW-1:0] nxt_kx, nxt_ky, nxt_x0, nxt_y0;
  logic [AW-1:0] nxt_addr, nxt_tap_row, nxt_win, nxt_win_row;
  logic          nxt_done;

  logic          tap_first_c, tap_last_c, gen_valid_c, push_c, frs_ready_c;
  logic [DW-1:0] frs_m_data;

  assign cfg_k_c     = CW'(cfg_k);
  assign cfg_s_c     = CW'(cfg_stride);
  assign cfg_w_c     = CW'(cfg_width);
  assign cfg_h_c     = CW'(cfg_height);
  assign cfg_pitch_c = AW'(cfg_width);
  assign cfg_ok_c    = (cfg_k_c != '0) && (cfg_s_c != '0) &&
                       (cfg_k_c <= cfg_w_c) && (cfg_k_c <= cfg_h_c);

  // S*W by shift-add over the stride bits; avoids a multiplier.
  always_comb begin
    cfg_spitch_c = '0;
    for (int unsigned i = 0; i < SW; i++) begin
      if (cfg_stride[i]) begin
        cfg_spitch_c = cfg_spitch_c + AW'(cfg_pitch_c << i);
      end
    end
  end

  // In IDLE the first tap is issued straight from the cfg inputs so the
  // first address reaches the slice in the same cycle start is sampled.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_k       = cfg_k_c;
      cur_s       = cfg_s_c;
      cur_w       = cfg_w_c;
      cur_h       = cfg_h_c;
      cur_pitch   = cfg_pitch_c;
      cur_spitch  = cfg_spitch_c;
      cur_kx      = '0;
      cur_ky      = '0;
      cur_x0      = '0;
      cur_y0      = '0;
      cur_addr    = cfg_base;
      cur_tap_row = cfg_base;
      cur_win     = cfg_base;
      cur_win_row = cfg_base;
    end else begin
      cur_k       = k_q;
      cur_s       = s_q;
      cur_w       = w_q;
      cur_h       = h_q;
      cur_pitch   = pitch_q;
      cur_spitch  = spitch_q;
      cur_kx      = kx_q;
      cur_ky      = ky_q;
      cur_x0      = x0_q;
      cur_y0      = y0_q;
      cur_addr    = addr_q;
      cur_tap_row = tap_row_addr_q;
      cur_win     = win_addr_q;
      cur_win_row = win_row_addr_q;
    end
  end

  assign tap_first_c = (cur_kx == '0) && (cur_ky == '0);
  assign tap_last_c  = (cur_kx == cur_k - CW'(1)) && (cur_ky == cur_k - CW'(1));

  // Step to the following tap: kx, then ky, then x0, then y0.
  always_comb begin
    nxt_kx      = cur_kx;
    nxt_ky      = cur_ky;
    nxt_x0      = cur_x0;
    nxt_y0      = cur_y0;
    nxt_addr    = cur_addr;
    nxt_tap_row = cur_tap_row;
    nxt_win     = cur_win;
    nxt_win_row = cur_win_row;
    nxt_done    = 1'b0;
    if (cur_kx != cur_k - CW'(1)) begin
      nxt_kx   = cur_kx + CW'(1);
      nxt_addr = cur_addr + AW'(1);
    end else if (cur_ky != cur_k - CW'(1)) begin
      nxt_kx      = '0;
      nxt_ky      = cur_ky + CW'(1);
      nxt_tap_row = cur_tap_row + cur_pitch;
      nxt_addr    = cur_tap_row + cur_pitch;
    end else if (cur_x0 + cur_s + cur_k <= cur_w) begin
      nxt_kx      = '0;
      nxt_ky      = '0;
      nxt_x0      = cur_x0 + cur_s;
      nxt_win     = cur_win + AW'(cur_s);
      nxt_tap_row = cur_win + AW'(cur_s);
      nxt_addr    = cur_win + AW'(cur_s);
    end else if (cur_y0 + cur_s + cur_k <= cur_h) begin
      nxt_kx      = '0;
      nxt_ky      = '0;
      nxt_x0      = '0;
      nxt_y0      = cur_y0 + cur_s;
      nxt_win_row = cur_win_row + cur_spitch;
      nxt_win     = cur_win_row + cur_spitch;
      nxt_tap_row = cur_win_row + cur_spitch;
      nxt_addr    = cur_win_row + cur_spitch;
    end else begin
      nxt_done = 1'b1;
    end
  end

  always_comb begin
    gen_valid_c = 1'b0;
    if (state_q == ST_IDLE) begin
      gen_valid_c = start && cfg_ok_c;
    end else if (state_q == ST_RUN) begin
      gen_valid_c = !gen_done_q;
    end
  end

  assign push_c = gen_valid_c && frs_ready_c;

  // Next-state and register update logic.
  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    s_d            = s_q;
    w_d            = w_q;
    h_d            = h_q;
    pitch_d        = pitch_q;
    spitch_d       = spitch_q;
    kx_d           = kx_q;
    ky_d           = ky_q;
    x0_d           = x0_q;
    y0_d           = y0_q;
    addr_d         = addr_q;
    tap_row_addr_d = tap_row_addr_q;
    win_addr_d     = win_addr_q;
    win_row_addr_d = win_row_addr_q;
    gen_done_d     = gen_done_q;
    err_d          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gen_done_d = 1'b0;
        if (start) begin
          k_d      = cfg_k_c;
          s_d      = cfg_s_c;
          w_d      = cfg_w_c;
          h_d      = cfg_h_c;
          pitch_d  = cfg_pitch_c;
          spitch_d = cfg_spitch_c;
          if (cfg_ok_c) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_FIN;
            err_d   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (gen_done_q && m_addr_valid && m_addr_ready) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (push_c) begin
      kx_d           = nxt_kx;
      ky_d           = nxt_ky;
      x0_d           = nxt_x0;
      y0_d           = nxt_y0;
      addr_d         = nxt_addr;
      tap_row_addr_d = nxt_tap_row;
      win_addr_d     = nxt_win;
      win_row_addr_d = nxt_win_row;
      gen_done_d     = nxt_done;
    end

    done_d = (state_d == ST_FIN);
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      k_q            <= '0;
      s_q            <= '0;
      w_q            <= '0;
      h_q            <= '0;
      pitch_q        <= '0;
      spitch_q       <= '0;
      kx_q           <= '0;
      ky_q           <= '0;
      x0_q           <= '0;
      y0_q           <= '0;
      addr_q         <= '0;
      tap_row_addr_q <= '0;
      win_addr_q     <= '0;
      win_row_addr_q <= '0;
      gen_done_q     <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      s_q            <= s_d;
      w_q            <= w_d;
      h_q            <= h_d;
      pitch_q        <= pitch_d;
      spitch_q       <= spitch_d;
      kx_q           <= kx_d;
      ky_q           <= ky_d;
      x0_q           <= x0_d;
      y0_q           <= y0_d;
      addr_q         <= addr_d;
      tap_row_addr_q <= tap_row_addr_d;
      win_addr_q     <= win_addr_d;
      win_row_addr_q <= win_row_addr_d;
      gen_done_q     <= gen_done_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

  axi_frs #(
    .DW(DW)
  ) u_frs (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (gen_valid_c),
    .s_ready_c(frs_ready_c),
    .s_data   ({cur_addr, tap_first_c, tap_last_c}),
    .m_valid  (m_addr_valid),
    .m_ready  (m_addr_ready),
    .m_data   (frs_m_data)
  );

  assign m_addr       = frs_m_data[DW-1:2];
  assign m_addr_first = frs_m_data[1];
  assign m_addr_last  = frs_m_data[0];
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = err_q;

endmodule

// File: tb/tb_conv_raddr_gen.sv
// Directed bench for conv_raddr_gen: window sequences, stride, backpressure,
// address wrap, rejected config and reset mid-job.
module tb_conv_raddr_gen;

  localparam int unsigned AW   = 13;
  localparam int unsigned DIMW = 8;
  localparam int unsigned KW   = 3;
  localparam int unsigned SW   = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [AW-1:0]   cfg_base = '0;
  logic [DIMW-1:0] cfg_width = '0;
  logic [DIMW-1:0] cfg_height = '0;
  logic [KW-1:0]   cfg_k = '0;
  logic [SW-1:0]   cfg_stride = '0;
  logic            busy, done, cfg_err;
  logic [AW-1:0]   m_addr;
  logic            m_addr_first, m_addr_last, m_addr_valid;
  logic            m_addr_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [AW-1:0] exp_addr[$];
  logic          exp_first[$];
  logic          exp_last[$];
  logic [AW-1:0] obs_addr[$];

  always #5 clk = ~clk;

  conv_raddr_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .cfg_base    (cfg_base),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .cfg_k       (cfg_k),
    .cfg_stride  (cfg_stride),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .m_addr      (m_addr),
    .m_addr_first(m_addr_first),
    .m_addr_last (m_addr_last),
    .m_addr_valid(m_addr_valid),
    .m_addr_ready(m_addr_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] obs_at(input int i);
    if (i < obs_addr.size()) return obs_addr[i];
    return 'x;
  endfunction

  // Reference tap order from the window definition (direct multiply).
  task automatic build_exp(input logic [AW-1:0] base, input int w, input int h,
                           input int k, input int s);
    exp_addr.delete();
    exp_first.delete();
    exp_last.delete();
    for (int y0 = 0; y0 + k <= h; y0 += s)
      for (int x0 = 0; x0 + k <= w; x0 += s)
        for (int ky = 0; ky < k; ky++)
          for (int kx = 0; kx < k; kx++) begin
            exp_addr.push_back(AW'(int'(base) + (y0 + ky) * w + x0 + kx));
            exp_first.push_back(kx == 0 && ky == 0);
            exp_last.push_back(kx == k - 1 && ky == k - 1);
          end
  endtask

  task automatic run_job(input logic [AW-1:0] base, input int w, input int h,
                         input int k, input int s, input bit rand_ready,
                         input bit poke, input int stop_after);
    int            idx;
    int            cyc;
    logic          rdy;
    logic          stalled;
    logic [AW-1:0] held_addr;
    logic          held_first, held_last;
    build_exp(base, w, h, k, s);
    obs_addr.delete();
    cfg_base   = base;
    cfg_width  = DIMW'(w);
    cfg_height = DIMW'(h);
    cfg_k      = KW'(k);
    cfg_stride = SW'(s);
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("first_valid_latency", 32'(m_addr_valid), 32'd1);
    check("busy_in_run", 32'(busy), 32'd1);
    idx = 0;
    cyc = 0;
    while (idx < exp_addr.size() && idx != stop_after) begin
      if (cyc >= 5000) begin
        check("timeout_beats", 32'(idx), 32'(exp_addr.size()));
        break;
      end
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      m_addr_ready = rdy;
      if (poke) begin
        start      = 1'b1;
        cfg_base   = AW'($urandom);
        cfg_k      = KW'(1);
        cfg_stride = SW'(3);
      end
      if (m_addr_valid && rdy) begin
        check("beat_addr", 32'(m_addr), 32'(exp_addr[idx]));
        check("beat_first", 32'(m_addr_first), 32'(exp_first[idx]));
        check("beat_last", 32'(m_addr_last), 32'(exp_last[idx]));
        obs_addr.push_back(m_addr);
        idx++;
      end
      stalled    = m_addr_valid && !rdy;
      held_addr  = m_addr;
      held_first = m_addr_first;
      held_last  = m_addr_last;
      @(posedge clk); #1;
      cyc++;
      if (stalled) begin
        check("stall_valid", 32'(m_addr_valid), 32'd1);
        check("stall_addr", 32'(m_addr), 32'(held_addr));
        check("stall_flags", 32'({m_addr_first, m_addr_last}), 32'({held_first, held_last}));
      end
      if (idx < exp_addr.size()) check("no_early_done", 32'(done), 32'd0);
    end
    start = 1'b0;
    if (idx == exp_addr.size()) begin
      m_addr_ready = 1'b0;
      check("done_after_last", 32'(done), 32'd1);
      check("no_err_on_valid_job", 32'(cfg_err), 32'd0);
      check("no_extra_beat", 32'(m_addr_valid), 32'd0);
      check("busy_drop_in_fin", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("idle_no_valid", 32'(m_addr_valid), 32'd0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(cfg_err), 32'd0);
    check({tag, "_valid"}, 32'(m_addr_valid), 32'd0);
    check({tag, "_first"}, 32'(m_addr_first), 32'd0);
    check({tag, "_last"}, 32'(m_addr_last), 32'd0);
    check({tag, "_addr"}, 32'(m_addr), 32'd0);
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // W=H=4, K=3, S=1, ready held high
    run_job(13'h100, 4, 4, 3, 1, 1'b0, 1'b0, -1);
    check("c1_count", 32'(obs_addr.size()), 32'd36);
    check("c1_b0", 32'(obs_at(0)), 32'h100);
    check("c1_b1", 32'(obs_at(1)), 32'h101);
    check("c1_b2", 32'(obs_at(2)), 32'h102);
    check("c1_b3", 32'(obs_at(3)), 32'h104);
    check("c1_b4", 32'(obs_at(4)), 32'h105);
    check("c1_b5", 32'(obs_at(5)), 32'h106);
    check("c1_b6", 32'(obs_at(6)), 32'h108);
    check("c1_b7", 32'(obs_at(7)), 32'h109);
    check("c1_b8", 32'(obs_at(8)), 32'h10A);
    check("c1_last_win_start", 32'(obs_at(27)), 32'h105);
    check("c1_last_win_end", 32'(obs_at(35)), 32'h10F);

    // W=H=5, K=3, S=2
    run_job(13'h100, 5, 5, 3, 2, 1'b0, 1'b0, -1);
    check("c2_count", 32'(obs_addr.size()), 32'd36);
    check("c2_win0", 32'(obs_at(0)), 32'h100);
    check("c2_win1", 32'(obs_at(9)), 32'h102);
    check("c2_win2", 32'(obs_at(18)), 32'h10A);
    check("c2_win3", 32'(obs_at(27)), 32'h10C);
    check("c2_final", 32'(obs_at(35)), 32'h118);

    // Random backpressure, with start/cfg toggling while busy
    run_job(13'h100, 4, 4, 3, 1, 1'b1, 1'b1, -1);
    check("c3_count", 32'(obs_addr.size()), 32'd36);
    check("c3_last", 32'(obs_at(35)), 32'h10F);

    // K=1 with address wrap
    run_job(13'h1FFE, 2, 2, 1, 1, 1'b0, 1'b0, -1);
    check("c4_count", 32'(obs_addr.size()), 32'd4);
    check("c4_b0", 32'(obs_at(0)), 32'h1FFE);
    check("c4_b1", 32'(obs_at(1)), 32'h1FFF);
    check("c4_b2", 32'(obs_at(2)), 32'h0000);
    check("c4_b3", 32'(obs_at(3)), 32'h0001);

    // Rejected config: K=5 > W=4
    cfg_base   = 13'h100;
    cfg_width  = 8'd4;
    cfg_height = 8'd4;
    cfg_k      = 3'd5;
    cfg_stride = 2'd1;
    start      = 1'b1;
    m_addr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("inv_done", 32'(done), 32'd1);
    check("inv_err", 32'(cfg_err), 32'd1);
    check("inv_no_valid", 32'(m_addr_valid), 32'd0);
    check("inv_not_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("inv_done_pulse", 32'(done), 32'd0);
    check("inv_err_pulse", 32'(cfg_err), 32'd0);
    check("inv_no_valid_after", 32'(m_addr_valid), 32'd0);
    @(posedge clk); #1;

    // Reset after the 10th handshake, then replay
    run_job(13'h100, 4, 4, 3, 1, 1'b0, 1'b0, 10);
    check("rst_progress", 32'(obs_addr.size()), 32'd10);
    m_addr_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrun_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(13'h100, 4, 4, 3, 1, 1'b0, 1'b0, -1);
    check("replay_count", 32'(obs_addr.size()), 32'd36);
    check("replay_first", 32'(obs_at(0)), 32'h100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
